// File: rtl/alu_exec_unit.sv
// RV64I execute block: ALU-control decode plus 64-bit ALU with one registered output stage.
// Optional MUL/MULW support is enabled by defining ALU_MUL_EN.
module alu_exec_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      ctrl_ALU_op,
    input  logic            is_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] data_a,
    input  logic [XLEN-1:0] data_b,
    output logic            out_valid,
    output logic [XLEN-1:0] data_out,
    output logic            zero,
    output logic            take_branch
);

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            sub_sel, mul_sel;
    logic [XLEN-1:0] sum, diff, prod;
    logic            eq, lt_s, lt_u;
    logic [5:0]      shamt;
    logic [XLEN-1:0] sll_res, srl_res, sra_res;
    logic [31:0]     a_w;
    logic [4:0]      shamt_w;
    logic [31:0]     sllw_res, srlw_res, sraw_res, word_res;
    logic [XLEN-1:0] result;
    logic            taken;

    // Immediate forms have no SUB; shifts read funct7[5] in both forms.
    assign sub_sel = !is_imm && funct7[5];
    assign mul_sel = MUL_EN && !is_imm && (funct7 == 7'b0000001) && (funct3 == 3'b000);

    assign sum  = data_a + data_b;
    assign diff = data_a - data_b;
`ifdef ALU_MUL_EN
    assign prod = data_a * data_b;
`else
    assign prod = '0;
`endif

    assign eq   = (data_a == data_b);
    assign lt_s = ($signed(data_a) < $signed(data_b));
    assign lt_u = (data_a < data_b);

    assign shamt   = data_b[5:0];
    assign sll_res = data_a << shamt;
    assign srl_res = data_a >> shamt;
    assign sra_res = $signed(data_a) >>> shamt;

    assign a_w      = data_a[31:0];
    assign shamt_w  = data_b[4:0];
    assign sllw_res = a_w << shamt_w;
    assign srlw_res = a_w >> shamt_w;
    assign sraw_res = $signed(a_w) >>> shamt_w;

    // Low halves of the 64-bit add/sub/mul equal the 32-bit word results.
    always_comb begin
        word_res = sum[31:0];
        case (funct3)
            3'b000: begin
                if (mul_sel)      word_res = prod[31:0];
                else if (sub_sel) word_res = diff[31:0];
            end
            3'b001:  word_res = sllw_res;
            3'b101:  word_res = funct7[5] ? sraw_res : srlw_res;
            default: word_res = sum[31:0];
        endcase
    end

    always_comb begin
        result = sum;
        taken  = 1'b0;
        case (ctrl_ALU_op)
            2'b00: result = sum;
            2'b01: begin
                result = diff;
                case (funct3)
                    3'b000:  taken = eq;
                    3'b001:  taken = !eq;
                    3'b100:  taken = lt_s;
                    3'b101:  taken = !lt_s;
                    3'b110:  taken = lt_u;
                    3'b111:  taken = !lt_u;
                    default: taken = 1'b0;
                endcase
            end
            2'b10: begin
                case (funct3)
                    3'b000:  result = mul_sel ? prod : (sub_sel ? diff : sum);
                    3'b001:  result = sll_res;
                    3'b010:  result = {{(XLEN-1){1'b0}}, lt_s};
                    3'b011:  result = {{(XLEN-1){1'b0}}, lt_u};
                    3'b100:  result = data_a ^ data_b;
                    3'b101:  result = funct7[5] ? sra_res : srl_res;
                    3'b110:  result = data_a | data_b;
                    default: result = data_a & data_b;
                endcase
            end
            default: result = {{(XLEN-32){word_res[31]}}, word_res};
        endcase
    end

    // Result registers hold their value across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            data_out    <= '0;
            zero        <= 1'b0;
            take_branch <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out    <= result;
                zero        <= (result == '0);
                take_branch <= taken;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against a behavioural RV64I model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  ctrl_ALU_op;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] data_a, data_b;
    logic        out_valid;
    logic [63:0] data_out;
    logic        zero;
    logic        take_branch;

    int checks = 0;
    int errors = 0;

    logic        exp_v = 1'b0, exp_z = 1'b0, exp_t = 1'b0;
    logic [63:0] exp_d = '0;
    bit          armed = 1'b0;
    string       last_tag = "none";

    alu_exec_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .ctrl_ALU_op(ctrl_ALU_op),
        .is_imm(is_imm), .funct3(funct3), .funct7(funct7), .data_a(data_a),
        .data_b(data_b), .out_valid(out_valid), .data_out(data_out), .zero(zero),
        .take_branch(take_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Behavioural model written straight from the ISA semantics.
    function automatic void ref_alu(input logic [1:0] op, input bit imm, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output bit t);
        longint sa, sb;
        int     wa, wb, w;
        bit     is_mul, is_sub;
        sa = longint'(a);
        sb = longint'(b);
        wa = int'(a[31:0]);
        wb = int'(b[31:0]);
`ifdef ALU_MUL_EN
        is_mul = !imm && f7 == 7'd1 && f3 == 3'd0;
`else
        is_mul = 1'b0;
`endif
        is_sub = !imm && f7[5];
        t = 1'b0;
        r = '0;
        if (op == 2'd0) r = a + b;
        else if (op == 2'd1) begin
            r = a - b;
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = (sa < sb);
                3'd5: t = (sa >= sb);
                3'd6: t = (a < b);
                3'd7: t = (a >= b);
                default: t = 1'b0;
            endcase
        end else if (op == 2'd2) begin
            case (f3)
                3'd0: r = is_mul ? a * b : (is_sub ? a - b : a + b);
                3'd1: r = a << b[5:0];
                3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
                3'd3: r = (a < b) ? 64'd1 : 64'd0;
                3'd4: r = a ^ b;
                3'd5: if (f7[5]) r = sa >>> b[5:0]; else r = a >> b[5:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else begin
            if (f3 == 3'd1) w = wa << b[4:0];
            else if (f3 == 3'd5 && f7[5]) w = wa >>> b[4:0];
            else if (f3 == 3'd5) w = int'(a[31:0] >> b[4:0]);
            else if (f3 == 3'd0 && is_mul) w = wa * wb;
            else if (f3 == 3'd0 && is_sub) w = wa - wb;
            else w = wa + wb;
            r = 64'(longint'(w));
        end
    endfunction

    // Check what the previous edge produced, then drive the next operation.
    task automatic step(input string tag, input bit rst, input bit v, input logic [1:0] op,
                        input bit imm, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        bit          t;
        @(negedge clk);
        if (armed) begin
            chk({last_tag, ".valid"}, {63'd0, out_valid}, {63'd0, exp_v});
            chk({last_tag, ".data"}, data_out, exp_d);
            chk({last_tag, ".zero"}, {63'd0, zero}, {63'd0, exp_z});
            chk({last_tag, ".br"}, {63'd0, take_branch}, {63'd0, exp_t});
        end
        reset = rst; in_valid = v; ctrl_ALU_op = op; is_imm = imm;
        funct3 = f3; funct7 = f7; data_a = a; data_b = b;
        if (!rst) begin
            exp_v = 0; exp_d = '0; exp_z = 0; exp_t = 0;
        end else begin
            exp_v = v;
            if (v) begin
                ref_alu(op, imm, f3, f7, a, b, r, t);
                exp_d = r; exp_z = (r == 64'd0); exp_t = t;
            end
        end
        armed    = 1'b1;
        last_tag = tag;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'({$urandom_range(0, 70)});
            4: return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [63:0] a, b;
        logic [6:0]  f7;
        reset = 0; in_valid = 1; ctrl_ALU_op = 0; is_imm = 0; funct3 = 0; funct7 = 0;
        data_a = 64'd9; data_b = 64'd9;

        step("rst0", 0, 1, 2'd0, 0, 3'd0, 7'd0, 64'd9, 64'd9);
        step("rst1", 0, 1, 2'd0, 0, 3'd0, 7'd0, 64'd9, 64'd9);
        settle();
        chk("rst.valid", {63'd0, out_valid}, 64'd0);
        chk("rst.data", data_out, 64'd0);
        chk("rst.zero", {63'd0, zero}, 64'd0);
        chk("rst.br", {63'd0, take_branch}, 64'd0);

        step("add57", 1, 1, 2'd0, 0, 3'd0, 7'd0, 64'd5, 64'd7);
        settle();
        chk("add57.lit", data_out, 64'd12);
        chk("add57.valid", {63'd0, out_valid}, 64'd1);

        step("sub0", 1, 1, 2'd2, 0, 3'd0, 7'h20, 64'h1234, 64'h1234);
        settle();
        chk("sub0.zero", {63'd0, zero}, 64'd1);
        step("addi", 1, 1, 2'd2, 1, 3'd0, 7'h20, 64'h1234, 64'h1234);
        settle();
        chk("addi.lit", data_out, 64'h2468);

        step("blt", 1, 1, 2'd1, 0, 3'd4, 7'd0, '1, 64'd1);
        settle();
        chk("blt.lit", {63'd0, take_branch}, 64'd1);
        step("bltu", 1, 1, 2'd1, 0, 3'd6, 7'd0, '1, 64'd1);
        settle();
        chk("bltu.lit", {63'd0, take_branch}, 64'd0);
        step("beq", 1, 1, 2'd1, 0, 3'd0, 7'd0, 64'd3, 64'd3);
        settle();
        chk("beq.lit", {63'd0, take_branch}, 64'd1);
        step("b010", 1, 1, 2'd1, 0, 3'd2, 7'd0, 64'd1, 64'd2);

        step("srai", 1, 1, 2'd2, 1, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd4);
        settle();
        chk("srai.lit", data_out, 64'hF800_0000_0000_0000);
        step("srlw", 1, 1, 2'd3, 0, 3'd5, 7'd0, 64'hFFFF_FFFF_8000_0000, 64'd31);
        settle();
        chk("srlw.lit", data_out, 64'd1);
        step("sraw", 1, 1, 2'd3, 0, 3'd5, 7'h20, 64'h0000_0000_8000_0000, 64'd4);
        step("addw", 1, 1, 2'd3, 0, 3'd0, 7'd0, 64'h7FFF_FFFF, 64'd1);
        settle();
        chk("addw.lit", data_out, 64'hFFFF_FFFF_8000_0000);

        step("mul", 1, 1, 2'd2, 0, 3'd0, 7'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        settle();
`ifdef ALU_MUL_EN
        chk("mul.lit", data_out, 64'hFFFF_FFFF_FFFF_FFFA);
`else
        chk("mul.lit", data_out, 64'd1);
`endif
        step("mulw", 1, 1, 2'd3, 0, 3'd0, 7'd1, 64'h1_0000_0003, 64'h7FFF_FFFF);

        step("b2b0", 1, 1, 2'd2, 0, 3'd4, 7'd0, 64'hF0F0, 64'h0FF0);
        step("b2b1", 1, 1, 2'd2, 0, 3'd6, 7'd0, 64'hF000, 64'h000F);
        step("b2b2", 1, 1, 2'd2, 0, 3'd3, 7'd0, 64'd1, 64'd2);
        step("idle0", 1, 0, 2'd0, 0, 3'd0, 7'd0, 64'd77, 64'd88);
        settle();
        chk("hold.valid", {63'd0, out_valid}, 64'd0);
        chk("hold.data", data_out, 64'd1);
        step("idle1", 1, 0, 2'd1, 0, 3'd0, 7'd0, 64'd0, 64'd0);

        for (int i = 0; i < 600; i++) begin
            a = pick64();
            b = ($urandom_range(0, 7) == 0) ? a : pick64();
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom());
            endcase
            step("rnd", $urandom_range(0, 49) != 0, $urandom_range(0, 6) != 0,
                 2'($urandom()), 1'($urandom()), 3'($urandom()), f7, a, b);
        end
        step("flush", 1, 0, 2'd0, 0, 3'd0, 7'd0, 64'd0, 64'd0);
        step("end", 1, 0, 2'd0, 0, 3'd0, 7'd0, 64'd0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- RV64I integer execute block: ALU-control decode (ALU op class + funct3/funct7) and 64-bit ALU in one unit.
- Produces a result, a zero flag and a branch-taken flag, with one registered pipeline stage.
- Sits between the decode/register-read logic and the writeback/PC-select logic of the single-issue core.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and controls valid this cycle.
- ctrl_ALU_op  input  2  op class: 00 add, 01 branch compare, 10 OP/OP-IMM, 11 OP-32/OP-IMM-32.
- is_imm  input  1  1 = immediate form; funct7 is ignored except for shifts.
- funct3  input  3  instruction bits [14:12].
- funct7  input  7  instruction bits [31:25].
- data_a  input  64  operand A (rs1 or pc).
- data_b  input  64  operand B (rs2 or immediate).
- out_valid  output  1  registered result valid.
- data_out  output  64  registered result.
- zero  output  1  registered; 1 when data_out == 0.
- take_branch  output  1  registered branch-condition result.

Behaviour:
- Reset is synchronous and active-low: reset==0 at a clock edge clears out_valid, data_out, zero and take_branch to 0. Reset applied mid-operation discards any in-flight result.
- Latency is 1 cycle. If in_valid=1 at edge N, the outputs hold that operation's result after edge N and out_valid=1.
- If in_valid=0 at an edge, out_valid goes to 0 and data_out, zero and take_branch hold their previous values.
- There is no backpressure. A new operation can be accepted every cycle.

Op class 00 (add):
- data_out = data_a + data_b, modulo 2^64.
- take_branch = 0.

Op class 01 (branch):
- data_out = data_a - data_b.
- take_branch by funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
- funct3 010 or 011 gives take_branch = 0.

Op class 10 (OP / OP-IMM), selected by funct3:
- 000: ADD, or SUB when is_imm=0 and funct7[5]=1.
- 001: SLL.
- 010: SLT (signed), result 1 or 0.
- 011: SLTU, result 1 or 0.
- 100: XOR.
- 101: SRL, or SRA when funct7[5]=1. This applies in both the register and immediate forms.
- 110: OR.
- 111: AND.
- Shift amount is data_b[5:0].
- take_branch = 0.

Op class 11 (word ops):
- Operates on the low 32 bits; the 32-bit result is sign-extended from bit 31.
- 000: ADDW, or SUBW when is_imm=0 and funct7[5]=1.
- 001: SLLW.
- 101: SRLW/SRAW, selected by funct7[5].
- Shift amount is data_b[4:0].
- Any other funct3 executes as ADDW.
- take_branch = 0.

Flags and arithmetic:
- zero is computed from the final 64-bit data_out of every class.
- Overflow wraps silently; there is no exception output.
- SRA/SRAW fill with the sign bit of data_a (the 32-bit value for SRAW).

Optional Feature:
- Macro: ALU_MUL_EN.
- When defined: in class 10 with is_imm=0, funct7=0000001 and funct3=000, data_out = low 64 bits of data_a*data_b (MUL). In class 11 with the same encoding, the low 32-bit product is sign-extended (MULW). Latency stays 1 cycle.
- When not defined: funct7=0000001 is decoded like funct7=0000000, so the encoding executes as ADD/ADDW.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 → out_valid=0, data_out=0, zero=0, take_branch=0. Release reset and issue class 00, a=5, b=7 → next cycle out_valid=1, data_out=12, zero=0.
- SUB/zero: class 10, funct3=000, funct7=0100000, is_imm=0, a=b=0x1234 → data_out=0, zero=1. The same operation with is_imm=1 → data_out=0x2468.
- Branch: class 01, a=-1, b=1 → funct3=100 (BLT) gives take_branch=1; funct3=110 (BLTU) gives take_branch=0; funct3=000 (BEQ) with a=b=3 gives take_branch=1.
- Shifts: class 10, funct3=101, funct7[5]=1, a=0x8000000000000000, b=4 → data_out=0xF800000000000000. Class 11 SRLW, a=0xFFFFFFFF80000000, b=31 → data_out=1.
- Word sign extension: class 11 ADDW, a=0x7FFFFFFF, b=1 → data_out=0xFFFFFFFF80000000.
- Back-to-back and hold: 3 consecutive valid ops, then in_valid=0 → 3 consecutive results each 1 cycle late; afterwards out_valid=0 and data_out holds the last value. With ALU_MUL_EN defined, MUL a=3, b=-2 → data_out=0xFFFFFFFFFFFFFFFA.
